// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and a synchronous-read instruction memory,
// and delivers {instr, pc} pairs to decode through a small prefetch queue.
module fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      IMEM_AW  = 14,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
  parameter int unsigned      QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_instr,
  output logic [XLEN-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [XLEN-1:0]    imem_wdata
);

  localparam int unsigned QAW   = $clog2(QDEPTH);
  localparam int unsigned CW    = QAW + 1;
  localparam int unsigned OCCW  = CW + 1;
  localparam int unsigned DEPTH = 2 ** IMEM_AW;

  logic [XLEN-1:0]    pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0]    q_instr_q [QDEPTH];
  logic [XLEN-1:0]    q_instr_d [QDEPTH];
  logic [XLEN-1:0]    q_pc_q [QDEPTH];
  logic [XLEN-1:0]    q_pc_d [QDEPTH];
  logic [QAW-1:0]     head_q, head_d;
  logic [QAW-1:0]     tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  logic [XLEN-1:0]    mem [DEPTH];
  logic [XLEN-1:0]    mem_rdata_q;
  logic [IMEM_AW-1:0] mem_raddr;

  logic               pop;
  logic               push;
  logic               issue;
  logic [OCCW-1:0]    occ;

  assign out_valid = (count_q != '0);
  assign out_instr = q_instr_q[head_q];
  assign out_pc    = q_pc_q[head_q];
  assign mem_raddr = pc_q[IMEM_AW+1:2];

  // Memory: write-then-read in one cycle returns the old word (NBA ordering).
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
    if (issue)   mem_rdata_q     <= mem[mem_raddr];
  end

  // Issue throttles on queue entries plus the outstanding read, so a push never overflows.
  always_comb begin
    pop           = out_valid && out_ready;
    push          = inflight_q && !redirect_valid;
    occ           = OCCW'(count_q) + OCCW'(inflight_q) - OCCW'(pop);
    issue         = !redirect_valid && (occ < OCCW'(QDEPTH));

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    q_instr_d     = q_instr_q;
    q_pc_d        = q_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc & ~XLEN'(3);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + XLEN'(4);
      end
      if (push) begin
        q_instr_d[tail_q] = mem_rdata_q;
        q_pc_d[tail_q]    = inflight_pc_q;
        tail_d            = tail_q + QAW'(1);
      end
      if (pop) head_d = head_q + QAW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      q_instr_q     <= q_instr_d;
      q_pc_q        <= q_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default config, a relocated reset vector,
// and a 16-word memory to exercise address wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, out_ready, redirect_valid, imem_we;
  logic [31:0] redirect_pc, imem_wdata;
  logic [13:0] imem_waddr;
  logic        v0, v1;
  logic [31:0] instr0, pc0, instr1, pc1;

  logic        reset2, ready2, we2;
  logic [3:0]  waddr2;
  logic [31:0] wdata2;
  logic        v2;
  logic [31:0] instr2, pc2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut0 (
    .clk(clk), .reset(reset), .out_valid(v0), .out_ready(out_ready),
    .out_instr(instr0), .out_pc(pc0), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata)
  );

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut1 (
    .clk(clk), .reset(reset), .out_valid(v1), .out_ready(out_ready),
    .out_instr(instr1), .out_pc(pc1), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata)
  );

  fetch_unit #(.IMEM_AW(4)) dut2 (
    .clk(clk), .reset(reset2), .out_valid(v2), .out_ready(ready2),
    .out_instr(instr2), .out_pc(pc2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem_we(we2), .imem_waddr(waddr2),
    .imem_wdata(wdata2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    reset2 = 1'b1; ready2 = 1'b0; we2 = 1'b0; waddr2 = '0; wdata2 = '0;

    // Preload both memory images while held in reset
    for (int i = 0; i < 40; i++) begin
      imem_we = 1'b1; imem_waddr = 14'(i); imem_wdata = 32'h1000_0000 + 32'(i);
      we2 = (i < 16); waddr2 = 4'(i); wdata2 = 32'h2000_0000 + 32'(i);
      step();
    end
    we2 = 1'b0;
    imem_waddr = 14'd64; imem_wdata = 32'hDEAD_BEEF;
    step();
    imem_we = 1'b0;
    step();

    check("rst_valid", 32'(v0), 32'd0);
    check("rst_pc", pc0, 32'd0);
    check("rst_instr", instr0, 32'd0);

    // Reset release latency and steady streaming
    reset = 1'b0; out_ready = 1'b1;
    step();
    check("lat_valid_e1", 32'(v0), 32'd0);
    step();
    check("lat_valid_e2", 32'(v0), 32'd1);
    check("stream_pc0", pc0, 32'd0);
    check("stream_instr0", instr0, 32'h1000_0000);
    check("rstvec_pc", pc1, 32'h0000_0100);
    check("rstvec_instr", instr1, 32'hDEAD_BEEF);
    for (int i = 1; i < 8; i++) begin
      step();
      check("stream_valid", 32'(v0), 32'd1);
      check("stream_pc", pc0, 32'(4 * i));
      check("stream_instr", instr0, 32'h1000_0000 + 32'(i));
    end

    // Backpressure at pc 0x8
    reset = 1'b1;
    step();
    check("rst2_valid", 32'(v0), 32'd0);
    reset = 1'b0;
    step(); step(); step(); step();
    check("bp_pc_start", pc0, 32'h8);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold_valid", 32'(v0), 32'd1);
      check("bp_hold_pc", pc0, 32'h8);
      check("bp_hold_instr", instr0, 32'h1000_0002);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("bp_rel_valid", 32'(v0), 32'd1);
      check("bp_rel_pc", pc0, 32'h8 + 32'(4 * k));
      check("bp_rel_instr", instr0, 32'h1000_0002 + 32'(k));
    end

    // Redirect with a read in flight; low address bits dropped
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    check("redir_gap1", 32'(v0), 32'd0);
    step();
    check("redir_gap2", 32'(v0), 32'd0);
    step();
    check("redir_valid", 32'(v0), 32'd1);
    check("redir_pc", pc0, 32'h40);
    check("redir_instr", instr0, 32'h1000_0010);
    step();
    check("redir_next_pc", pc0, 32'h44);
    check("redir_next_instr", instr0, 32'h1000_0011);

    // Redirect while queue full
    out_ready = 1'b0;
    step(); step();
    check("full_hold_pc", pc0, 32'h44);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0060;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    check("full_redir_gap1", 32'(v0), 32'd0);
    step();
    check("full_redir_gap2", 32'(v0), 32'd0);
    step();
    check("full_redir_pc", pc0, 32'h60);
    check("full_redir_instr", instr0, 32'h1000_0018);

    // Redirect coincident with a pop
    step();
    check("pre_pop_pc", pc0, 32'h64);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    check("pop_redir_gap1", 32'(v0), 32'd0);
    step();
    check("pop_redir_gap2", 32'(v0), 32'd0);
    step();
    check("pop_redir_valid", 32'(v0), 32'd1);
    check("pop_redir_pc", pc0, 32'h80);
    check("pop_redir_instr", instr0, 32'h1000_0020);

    // Small memory: address wrap and mid-stream reset
    reset2 = 1'b0; ready2 = 1'b1;
    step(); step();
    check("wrap_first_pc", pc2, 32'h0);
    check("wrap_first_instr", instr2, 32'h2000_0000);
    for (int i = 1; i < 16; i++) step();
    check("wrap_pc3c", pc2, 32'h3C);
    check("wrap_instr3c", instr2, 32'h2000_000F);
    step();
    check("wrap_pc40", pc2, 32'h40);
    check("wrap_instr40", instr2, 32'h2000_0000);
    step();
    check("wrap_pc44", pc2, 32'h44);
    check("wrap_instr44", instr2, 32'h2000_0001);
    reset2 = 1'b1;
    step();
    check("midrst_valid", 32'(v2), 32'd0);
    check("midrst_pc", pc2, 32'd0);
    reset2 = 1'b0;
    step();
    check("midrst_lat_valid", 32'(v2), 32'd0);
    step();
    check("midrst_restart_valid", 32'(v2), 32'd1);
    check("midrst_restart_pc", pc2, 32'd0);
    check("midrst_restart_instr", instr2, 32'h2000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
